// File: rtl/robin_pkg.sv
// robin_pkg: shared types and defaults for the uart stream FIFOs.
//   fifo_state_e   : read-side prefetch state (EMPTY / FETCH / VALID)
//   DEF_DATA_WIDTH : default entry width
//   DEF_ADDR_WIDTH : default log2 depth
package robin_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing presented, nothing in flight
        ST_FETCH = 2'd1,   // RAM read issued this cycle, head lands next edge
        ST_VALID = 2'd2    // head entry presented on rd_data
    } fifo_state_e;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, synchronous write, registered read.
// Written so it maps onto an iCE40 EBR (no reset on array or read register).
//   CLK   : clock
//   we    : write enable, waddr/wdata written at posedge
//   re    : read enable, rdata <= mem[raddr] at posedge
//   rdata : registered read data, holds while re is low
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/uart_stream_fifo.sv
// uart_stream_fifo: synchronous FIFO with valid/ready on both sides and a
// first-word-fall-through read port, used on the uart RX and TX paths.
//   CLK, RST      : clock, asynchronous active-high reset
//   flush         : synchronous clear of contents (overflow flag kept)
//   wr_valid/wr_ready/wr_data : write handshake, wr_ready = !full
//   rd_valid/rd_ready/rd_data : read handshake, rd_data is the head entry
//   count         : entries accepted and not yet popped (0..DEPTH)
//   almost_full   : count >= AF_LEVEL (registered)
//   overflow      : sticky, set on write attempt while full
//   clr_overflow  : clears overflow (a new overflow in the same cycle wins)
module uart_stream_fifo
    import robin_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    fifo_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  af_q, ovf_q;
    logic                  push, pop, rd_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Full/empty come from the registered count only, so a pop never
    // re-opens wr_ready in the same cycle.
    assign wr_ready    = (count_q != DEPTH_C);
    assign rd_valid    = (state_q == ST_VALID);
    // The RAM read register is the output register; it has no reset (EBR),
    // so it is masked to zero whenever no head is presented.
    assign rd_data     = rd_valid ? ram_rdata : '0;
    assign count       = count_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;

    assign push = wr_valid & wr_ready & ~flush;
    assign pop  = rd_valid & rd_ready & ~flush;

    always_comb begin
        count_d = count_q;
        if (flush)              count_d = '0;
        else if (push && !pop)  count_d = count_q + ONE_C;
        else if (pop && !push)  count_d = count_q - ONE_C;
    end

    // Prefetch FSM. count includes the presented head, so in VALID another
    // entry is waiting in RAM exactly when count > 1.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (count_q != '0) state_d = ST_FETCH;
                ST_FETCH: begin
                    rd_en   = 1'b1;
                    state_d = ST_VALID;
                end
                ST_VALID: if (pop) begin
                    if (count_q > ONE_C) rd_en = 1'b1;        // next head, no bubble
                    else if (push)       state_d = ST_FETCH;  // entry written this edge
                    else                 state_d = ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            af_q    <= (count_d >= AF_C);
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
                if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_valid && !wr_ready && !flush) ovf_q <= 1'b1;
            else if (clr_overflow)               ovf_q <= 1'b0;
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .CLK   (CLK),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

endmodule
